// File: rtl/vrf_banked_collector.sv
// Banked vector register file with a request/response operand collector.
// Ports:
//   clk, rstn          clock and asynchronous active-low reset
//   flush              abandon any in-flight request
//   req_*              operand request (addr/use/tag per request), valid/ready
//   rsp_*              collected operands, echoed use and tag, valid/ready
//   wr_*               writeback ports (addr/mask/data); wr_conflict = not granted
//   data_v0            shadow copy of v0 (all segments)
module vrf_banked_collector #(
    parameter int unsigned NUM_VREG   = 32,
    parameter int unsigned VLEN       = 256,
    parameter int unsigned SEG_W      = 64,
    parameter int unsigned NUM_RD     = 3,
    parameter int unsigned NUM_WR     = 2,
    parameter int unsigned BANK_NUM   = 4,
    parameter int unsigned BANK_RPORT = 2,
    parameter int unsigned BANK_WPORT = 1,
    parameter int unsigned TAG_W      = 6,
    localparam int unsigned NSEG      = VLEN / SEG_W,
    localparam int unsigned ADDR_W    = $clog2(NUM_VREG * NSEG)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       req_vld,
    output logic                       req_rdy,
    input  logic [NUM_RD*ADDR_W-1:0]   req_addr,
    input  logic [NUM_RD-1:0]          req_use,
    input  logic [TAG_W-1:0]           req_tag,
    output logic                       rsp_vld,
    input  logic                       rsp_rdy,
    output logic [NUM_RD*SEG_W-1:0]    rsp_data,
    output logic [NUM_RD-1:0]          rsp_use,
    output logic [TAG_W-1:0]           rsp_tag,
    input  logic [NUM_WR-1:0]          wr_vld,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*SEG_W-1:0]    wr_mask,
    input  logic [NUM_WR*SEG_W-1:0]    wr_data,
    output logic [NUM_WR-1:0]          wr_conflict,
    output logic [VLEN-1:0]            data_v0
);

    localparam int unsigned BANK_W = $clog2(BANK_NUM);
    localparam int unsigned ROW_W  = ADDR_W - BANK_W;
    localparam int unsigned ROWS   = NUM_VREG * NSEG / BANK_NUM;
    localparam int unsigned SEGI_W = $clog2(NSEG);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [SEG_W-1:0]          mem_q [BANK_NUM][ROWS];

    logic [1:0]                state_q, state_d;
    logic [NUM_RD-1:0]         pending_q, pending_d;
    logic [NUM_RD*ADDR_W-1:0]  op_addr_q, op_addr_d;
    logic                      rsp_vld_q, rsp_vld_d;
    logic [NUM_RD*SEG_W-1:0]   rsp_data_q, rsp_data_d;
    logic [NUM_RD-1:0]         rsp_use_q, rsp_use_d;
    logic [TAG_W-1:0]          rsp_tag_q, rsp_tag_d;
    logic [VLEN-1:0]           data_v0_q, data_v0_d;

    logic [ADDR_W-1:0]         wa   [NUM_WR];
    logic [BANK_W-1:0]         wb   [NUM_WR];
    logic [ROW_W-1:0]          wrow [NUM_WR];
    logic [NUM_WR-1:0]         wr_gnt;

    logic [ADDR_W-1:0]         oa      [NUM_RD];
    logic [SEG_W-1:0]          rd_word [NUM_RD];
    logic [NUM_RD-1:0]         rd_gnt;

    // Write arbitration: up to BANK_WPORT grants per bank, lowest port first
    always_comb begin : wr_arb
        int unsigned wcnt [BANK_NUM];
        for (int b = 0; b < BANK_NUM; b++) wcnt[b] = 0;
        wr_gnt = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            wa[i]   = wr_addr[i*ADDR_W +: ADDR_W];
            wb[i]   = wa[i][BANK_W-1:0];
            wrow[i] = wa[i][ADDR_W-1:BANK_W];
            if (wr_vld[i] && (wcnt[wb[i]] < BANK_WPORT)) begin
                wr_gnt[i]    = 1'b1;
                wcnt[wb[i]] = wcnt[wb[i]] + 1;
            end
        end
    end

    assign wr_conflict = wr_vld & ~wr_gnt;

    // Bank storage, not reset; bitwise updates so a later port wins per bit
    always_ff @(posedge clk) begin : bank_write
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_gnt[i]) begin
                for (int k = 0; k < SEG_W; k++) begin
                    if (wr_mask[i*SEG_W + k]) mem_q[wb[i]][wrow[i]][k] <= wr_data[i*SEG_W + k];
                end
            end
        end
    end

    // Read arbitration: up to BANK_RPORT pending operands per bank, lowest first;
    // an operand hitting this cycle's granted write waits one cycle for the new data
    always_comb begin : rd_arb
        int unsigned rcnt [BANK_NUM];
        logic        raw;
        for (int b = 0; b < BANK_NUM; b++) rcnt[b] = 0;
        rd_gnt = '0;
        for (int o = 0; o < NUM_RD; o++) begin
            oa[o]      = op_addr_q[o*ADDR_W +: ADDR_W];
            rd_word[o] = mem_q[oa[o][BANK_W-1:0]][oa[o][ADDR_W-1:BANK_W]];
            raw        = 1'b0;
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_gnt[i] && (wa[i] == oa[o])) raw = 1'b1;
            end
            if ((state_q == S_COLLECT) && pending_q[o] && !raw &&
                (rcnt[oa[o][BANK_W-1:0]] < BANK_RPORT)) begin
                rd_gnt[o] = 1'b1;
                rcnt[oa[o][BANK_W-1:0]] = rcnt[oa[o][BANK_W-1:0]] + 1;
            end
        end
    end

    // v0 shadow follows granted writes to vreg 0 only
    always_comb begin : v0_upd
        data_v0_d = data_v0_q;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_gnt[i] && (wa[i][ADDR_W-1:SEGI_W] == '0)) begin
                for (int s = 0; s < NSEG; s++) begin
                    if (32'(wa[i][SEGI_W-1:0]) == s) begin
                        for (int k = 0; k < SEG_W; k++) begin
                            if (wr_mask[i*SEG_W + k]) data_v0_d[s*SEG_W + k] = wr_data[i*SEG_W + k];
                        end
                    end
                end
            end
        end
    end

    // Collector FSM next-state and payload capture
    always_comb begin : fsm
        state_d    = state_q;
        pending_d  = pending_q;
        op_addr_d  = op_addr_q;
        rsp_data_d = rsp_data_q;
        rsp_use_d  = rsp_use_q;
        rsp_tag_d  = rsp_tag_q;
        case (state_q)
            S_IDLE: begin
                if (req_vld) begin
                    op_addr_d  = req_addr;
                    pending_d  = req_use;
                    rsp_use_d  = req_use;
                    rsp_tag_d  = req_tag;
                    rsp_data_d = '0;
                    state_d    = (req_use == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                for (int o = 0; o < NUM_RD; o++) begin
                    if (rd_gnt[o]) rsp_data_d[o*SEG_W +: SEG_W] = rd_word[o];
                end
                pending_d = pending_q & ~rd_gnt;
                if (pending_d == '0) state_d = S_DONE;
            end
            S_DONE: begin
                if (rsp_rdy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
        rsp_vld_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin : regs
        if (!rstn) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            op_addr_q  <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_use_q  <= '0;
            rsp_tag_q  <= '0;
            data_v0_q  <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            op_addr_q  <= op_addr_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            rsp_use_q  <= rsp_use_d;
            rsp_tag_q  <= rsp_tag_d;
            data_v0_q  <= data_v0_d;
        end
    end

    assign req_rdy  = (state_q == S_IDLE);
    assign rsp_vld  = rsp_vld_q;
    assign rsp_data = rsp_data_q;
    assign rsp_use  = rsp_use_q;
    assign rsp_tag  = rsp_tag_q;
    assign data_v0  = data_v0_q;

endmodule

// File: tb/tb_vrf_banked_collector.sv
// Testbench for vrf_banked_collector: arbitration table, directed collector
// sequences (latency, bank stalls, read-after-write, backpressure, flush,
// reset) and randomized traffic against a flat-memory reference model.
module tb_vrf_banked_collector;

    localparam int NUM_RD = 3;
    localparam int NUM_WR = 2;
    localparam int SEG_W  = 64;
    localparam int ADDR_W = 7;
    localparam int TAG_W  = 6;
    localparam int VLEN   = 256;
    localparam int NBANK  = 4;
    localparam int RPORT  = 2;
    localparam int WPORT  = 1;

    logic                      clk = 1'b0;
    logic                      rstn;
    logic                      flush;
    logic                      req_vld;
    logic                      req_rdy;
    logic [NUM_RD*ADDR_W-1:0]  req_addr;
    logic [NUM_RD-1:0]         req_use;
    logic [TAG_W-1:0]          req_tag;
    logic                      rsp_vld;
    logic                      rsp_rdy;
    logic [NUM_RD*SEG_W-1:0]   rsp_data;
    logic [NUM_RD-1:0]         rsp_use;
    logic [TAG_W-1:0]          rsp_tag;
    logic [NUM_WR-1:0]         wr_vld;
    logic [NUM_WR*ADDR_W-1:0]  wr_addr;
    logic [NUM_WR*SEG_W-1:0]   wr_mask;
    logic [NUM_WR*SEG_W-1:0]   wr_data;
    logic [NUM_WR-1:0]         wr_conflict;
    logic [VLEN-1:0]           data_v0;

    vrf_banked_collector dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
        .req_use(req_use), .req_tag(req_tag),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
        .rsp_use(rsp_use), .rsp_tag(rsp_tag),
        .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
        .wr_conflict(wr_conflict), .data_v0(data_v0)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: flat memory indexed by segment address
    logic [SEG_W-1:0] m_mem [128];
    logic [VLEN-1:0]  m_v0;
    int               m_phase;      // 0 waiting for request, 1 gathering, 2 holding response
    logic [ADDR_W-1:0] m_addr [NUM_RD];
    logic [SEG_W-1:0]  m_data [NUM_RD];
    logic [NUM_RD-1:0] m_need;
    logic [NUM_RD-1:0] m_use;
    logic [TAG_W-1:0]  m_tag;

    typedef struct {
        logic [1:0]  vld;
        logic [6:0]  a0;
        logic [6:0]  a1;
        logic [63:0] m0;
        logic [63:0] d0;
        logic [63:0] m1;
        logic [63:0] d1;
        logic [1:0]  exp_c;
    } wvec_t;

    wvec_t tbl [6];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // A write port is granted if fewer than WPORT lower-numbered valid ports hit its bank
    function automatic logic [1:0] m_wgrant();
        logic [1:0] g = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            int same = 0;
            for (int j = 0; j < i; j++)
                if (wr_vld[j] && (wr_addr[j*ADDR_W +: ADDR_W] % NBANK) == (wr_addr[i*ADDR_W +: ADDR_W] % NBANK))
                    same++;
            if (wr_vld[i] && same < WPORT) g[i] = 1'b1;
        end
        return g;
    endfunction

    task automatic model_update(input logic [1:0] g);
        logic [NUM_RD-1:0] rd = '0;
        if (flush) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (req_vld) begin
                for (int o = 0; o < NUM_RD; o++) begin
                    m_addr[o] = req_addr[o*ADDR_W +: ADDR_W];
                    m_data[o] = '0;
                end
                m_use   = req_use;
                m_tag   = req_tag;
                m_need  = req_use;
                m_phase = (req_use == 0) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            for (int o = 0; o < NUM_RD; o++) begin
                if (m_need[o]) begin
                    bit hit = 0;
                    int cnt = 0;
                    for (int i = 0; i < NUM_WR; i++)
                        if (g[i] && wr_addr[i*ADDR_W +: ADDR_W] == m_addr[o]) hit = 1;
                    for (int p = 0; p < o; p++)
                        if (rd[p] && (m_addr[p] % NBANK) == (m_addr[o] % NBANK)) cnt++;
                    if (!hit && cnt < RPORT) begin
                        rd[o]     = 1'b1;
                        m_data[o] = m_mem[m_addr[o]];
                    end
                end
            end
            m_need = m_need & ~rd;
            if (m_need == 0) m_phase = 2;
        end else if (rsp_rdy) begin
            m_phase = 0;
        end
        for (int i = 0; i < NUM_WR; i++) begin
            if (g[i]) begin
                int a = int'(wr_addr[i*ADDR_W +: ADDR_W]);
                for (int k = 0; k < SEG_W; k++) begin
                    if (wr_mask[i*SEG_W + k]) begin
                        m_mem[a][k] = wr_data[i*SEG_W + k];
                        if (a < 4) m_v0[a*SEG_W + k] = wr_data[i*SEG_W + k];
                    end
                end
            end
        end
    endtask

    // One clock: check combinational outputs, advance model, check registered outputs
    task automatic step();
        logic [1:0] g;
        #1;
        g = m_wgrant();
        chk("wr_conflict", wr_conflict, wr_vld & ~g);
        chk("req_rdy", req_rdy, m_phase == 0);
        model_update(g);
        @(posedge clk);
        #1;
        chk("rsp_vld", rsp_vld, m_phase == 2);
        chk("data_v0", data_v0, m_v0);
        if (m_phase == 2) begin
            chk("rsp_tag", rsp_tag, m_tag);
            chk("rsp_use", rsp_use, m_use);
            for (int o = 0; o < NUM_RD; o++)
                if (m_use[o]) chk($sformatf("rsp_data%0d", o), rsp_data[o*SEG_W +: SEG_W], m_data[o]);
        end
        @(negedge clk);
    endtask

    task automatic collect(input logic [20:0] addrs, input logic [2:0] use_mask,
                           input logic [5:0] tag, input int exp_lat, input string name);
        int lat = 0;
        req_vld  = 1'b1;
        req_addr = addrs;
        req_use  = use_mask;
        req_tag  = tag;
        rsp_rdy  = 1'b0;
        do begin
            step();
            lat++;
            req_vld = 1'b0;
        end while (!rsp_vld && lat < 20);
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_tag"}, rsp_tag, tag);
    endtask

    task automatic release_rsp();
        rsp_rdy = 1'b1;
        step();
        rsp_rdy = 1'b0;
    endtask

    function automatic logic [6:0] pick_addr();
        return ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 15)) : 7'($urandom_range(0, 127));
    endfunction

    initial begin
        int lat;
        logic [VLEN-1:0]          v0_snap;
        logic [NUM_RD*SEG_W-1:0]  data_snap;

        tbl[0] = '{2'b11, 7'd3, 7'd7, '1, 64'h1111, '1, 64'h2222, 2'b10};
        tbl[1] = '{2'b10, 7'd3, 7'd7, '1, 64'h1111, '1, 64'h3333, 2'b00};
        tbl[2] = '{2'b01, 7'd1, 7'd0, 64'hFF, 64'h1234, '0, '0, 2'b00};
        tbl[3] = '{2'b11, 7'd5, 7'd1, '0, '0, '1, 64'hFFFF_0000_BEEF_0000, 2'b10};
        tbl[4] = '{2'b11, 7'd0, 7'd1, '0, '0, '0, '0, 2'b00};
        tbl[5] = '{2'b11, 7'd2, 7'd2, '0, '0, '0, '0, 2'b10};

        rstn = 1'b0; flush = 1'b0; req_vld = 1'b0; req_addr = '0; req_use = '0; req_tag = '0;
        rsp_rdy = 1'b0; wr_vld = '0; wr_addr = '0; wr_mask = '0; wr_data = '0;
        m_phase = 0; m_v0 = '0; m_need = '0; m_use = '0; m_tag = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_rsp_vld", rsp_vld, 1'b0);
        chk("reset_rsp_data", rsp_data, '0);
        chk("reset_rsp_use", rsp_use, '0);
        chk("reset_rsp_tag", rsp_tag, '0);
        chk("reset_data_v0", data_v0, '0);
        chk("reset_req_rdy", req_rdy, 1'b1);
        @(negedge clk);
        rstn = 1'b1;

        // Preload every segment address, two banks per cycle
        for (int a = 0; a < 128; a += 2) begin
            wr_vld  = 2'b11;
            wr_addr = {7'(a + 1), 7'(a)};
            wr_mask = '1;
            wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
        end
        wr_vld = '0;

        // Write arbitration vectors
        for (int k = 0; k < 6; k++) begin
            wr_vld  = tbl[k].vld;
            wr_addr = {tbl[k].a1, tbl[k].a0};
            wr_mask = {tbl[k].m1, tbl[k].m0};
            wr_data = {tbl[k].d1, tbl[k].d0};
            #1;
            chk($sformatf("tbl%0d_conflict", k), wr_conflict, tbl[k].exp_c);
            v0_snap = data_v0;
            step();
            if (k == 2) chk("v0_seg1_low_byte", data_v0[71:64], 8'h34);
            if (k == 3) chk("v0_denied_unchanged", data_v0, v0_snap);
        end
        wr_vld = '0;
        chk("retry_stored", m_mem[7], 64'h3333);

        // Three different banks: two-cycle latency
        collect({7'd2, 7'd1, 7'd0}, 3'b111, 6'h15, 2, "banks_distinct");
        release_rsp();

        // All in bank 0: one extra round
        collect({7'd12, 7'd8, 7'd4}, 3'b111, 6'h07, 3, "bank0_triple");
        release_rsp();

        // Read-after-write stall on operand 0
        req_vld = 1'b1; req_addr = {7'd0, 7'd0, 7'd5}; req_use = 3'b001; req_tag = 6'h2A;
        step();
        req_vld = 1'b0; lat = 1;
        wr_vld = 2'b01; wr_addr = {7'd0, 7'd5}; wr_mask = {64'd0, {64{1'b1}}}; wr_data = {64'd0, 64'hA5A5};
        step();
        lat++;
        wr_vld = '0;
        chk("raw_deferred", rsp_vld, 1'b0);
        while (!rsp_vld && lat < 20) begin
            step();
            lat++;
        end
        chk("raw_latency", lat, 3);
        chk("raw_data", rsp_data[63:0], 64'hA5A5);
        release_rsp();

        // Backpressure: response held stable while rsp_rdy low
        collect({7'd10, 7'd9, 7'd8}, 3'b111, 6'h33, 2, "stall");
        data_snap = rsp_data;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("stall_vld", rsp_vld, 1'b1);
            chk("stall_data", rsp_data, data_snap);
            chk("stall_req_rdy", req_rdy, 1'b0);
        end
        release_rsp();

        // Flush abandons a gathering request
        req_vld = 1'b1; req_addr = {7'd12, 7'd8, 7'd4}; req_use = 3'b111; req_tag = 6'h01;
        step();
        req_vld = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_rsp_vld", rsp_vld, 1'b0);
        chk("flush_req_rdy", req_rdy, 1'b1);

        // Reset mid-gather: back to idle, storage retained
        req_vld = 1'b1; req_addr = {7'd12, 7'd8, 7'd4}; req_use = 3'b111; req_tag = 6'h02;
        step();
        req_vld = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rst_mid_rsp_vld", rsp_vld, 1'b0);
        m_phase = 0;
        m_v0    = '0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_release_req_rdy", req_rdy, 1'b1);
        chk("rst_release_v0", data_v0, '0);
        collect({7'd12, 7'd8, 7'd4}, 3'b111, 6'h03, 3, "after_reset");
        release_rsp();

        // Randomized traffic
        for (int c = 0; c < 500; c++) begin
            flush   = ($urandom_range(0, 31) == 0);
            req_vld = 1'($urandom_range(0, 1));
            for (int o = 0; o < NUM_RD; o++) req_addr[o*ADDR_W +: ADDR_W] = pick_addr();
            req_use = 3'($urandom_range(0, 7));
            req_tag = 6'($urandom());
            rsp_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_WR; i++) begin
                wr_vld[i] = 1'($urandom_range(0, 1));
                wr_addr[i*ADDR_W +: ADDR_W] = pick_addr();
                wr_mask[i*SEG_W +: SEG_W]   = {$urandom(), $urandom()};
                wr_data[i*SEG_W +: SEG_W]   = {$urandom(), $urandom()};
            end
            step();
        end
        flush = 1'b0; req_vld = 1'b0; wr_vld = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
